// File: rtl/ram_ctrl_pkg.sv
// Shared sizing constants and address helpers for the SRIO packet buffer.
package ram_ctrl_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 10;
  localparam int BANK_NUM   = 8;
  localparam int SEQ_WIDTH  = 3;

  typedef logic [ADDR_WIDTH-1:0] word_addr_t;

  // Byte offset from the hash unit to a 64-bit word index.
  function automatic word_addr_t offset_to_word(input logic [ADDR_WIDTH-1:0] offset);
    return {3'b000, offset[ADDR_WIDTH-1:3]};
  endfunction

endpackage

// File: rtl/pack_bank_ram.sv
// One packet bank: simple dual-port RAM, one write port and one registered,
// read-first read port. Contents are never reset.
module pack_bank_ram #(
  parameter int DATA_WIDTH = ram_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_ctrl_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  import ram_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Same-address collisions return the old word: the read samples before the write lands.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pack_ram_controller.sv
// Packet buffer between SRIO receive and hash match: packets land in the bank
// named by their sequence number; hash hits read one word back with 2-cycle latency.
module pack_ram_controller #(
  parameter int DATA_WIDTH = ram_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ram_ctrl_pkg::ADDR_WIDTH,
  parameter int BANK_NUM   = ram_ctrl_pkg::BANK_NUM,
  parameter int SEQ_WIDTH  = ram_ctrl_pkg::SEQ_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic [ADDR_WIDTH-1:0] data_length_in,
  input  logic [SEQ_WIDTH-1:0]  pack_seq_in,
  input  logic [SEQ_WIDTH-1:0]  hash_pack_seq_in,
  input  logic                  hash_hit_in,
  input  logic [ADDR_WIDTH-1:0] hash_addr_offset_in,
  output logic                  hash_pack_comp_out,
  output logic                  rd_data_valid_out,
  output logic [DATA_WIDTH-1:0] rd_data_out
);
  import ram_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic                  r_valid_d;
  logic [SEQ_WIDTH-1:0]  r_wr_bank;
  logic [ADDR_WIDTH:0]   r_wr_addr;
  logic [ADDR_WIDTH:0]   r_wr_cnt [BANK_NUM];
  logic [ADDR_WIDTH-1:0] r_len_unused [BANK_NUM];
  logic [BANK_NUM-1:0]   r_bank_written;
  logic [SEQ_WIDTH-1:0]  r_hseq_prev;
  logic                  r_hseq_vld;
  logic                  r_rd_acc;
  logic [SEQ_WIDTH-1:0]  r_rd_bank;
  word_addr_t            r_rd_word;
  logic                  r_ram_acc;
  logic [SEQ_WIDTH-1:0]  r_ram_bank;

  logic                  w_pkt_start;
  logic                  w_pkt_end;
  logic                  w_we;
  logic [SEQ_WIDTH-1:0]  w_wbank;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic                  w_hseq_chg;
  logic                  w_bank_open;
  logic                  w_hit_acc;
  word_addr_t            w_hit_word;
  logic [DATA_WIDTH-1:0] w_ram_q [BANK_NUM];

  assign w_pkt_start = data_valid_in & ~r_valid_d;
  assign w_pkt_end   = ~data_valid_in & r_valid_d;
  // r_wr_addr[ADDR_WIDTH] marks a full bank: further beats of the packet are dropped.
  assign w_we        = w_pkt_start | (data_valid_in & ~r_wr_addr[ADDR_WIDTH]);
  assign w_wbank     = w_pkt_start ? pack_seq_in : r_wr_bank;
  assign w_waddr     = w_pkt_start ? {ADDR_WIDTH{1'b0}} : r_wr_addr[ADDR_WIDTH-1:0];

  assign w_hseq_chg  = r_hseq_vld & (hash_pack_seq_in != r_hseq_prev);
  assign w_bank_open = r_valid_d & (r_wr_bank == hash_pack_seq_in);
  assign w_hit_word  = offset_to_word(hash_addr_offset_in);
  assign w_hit_acc   = hash_hit_in
                     & ({1'b0, w_hit_word} < r_wr_cnt[hash_pack_seq_in])
                     & (r_bank_written[hash_pack_seq_in] | w_bank_open);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d      <= 1'b0;
      r_wr_bank      <= {SEQ_WIDTH{1'b0}};
      r_wr_addr      <= {(ADDR_WIDTH+1){1'b0}};
      r_bank_written <= {BANK_NUM{1'b0}};
      r_hseq_prev    <= {SEQ_WIDTH{1'b0}};
      r_hseq_vld     <= 1'b0;
      hash_pack_comp_out <= 1'b0;
      for (int b = 0; b < BANK_NUM; b++) begin
        r_wr_cnt[b]     <= {(ADDR_WIDTH+1){1'b0}};
        r_len_unused[b] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      r_valid_d <= data_valid_in;
      if (w_pkt_start) begin
        r_wr_bank                 <= pack_seq_in;
        r_wr_addr                 <= CNT_ONE;
        r_len_unused[pack_seq_in] <= data_length_in;
      end else if (w_we) begin
        r_wr_addr <= r_wr_addr + CNT_ONE;
      end
      if (w_we) begin
        r_wr_cnt[w_wbank] <= {1'b0, w_waddr} + CNT_ONE;
      end
      r_hseq_prev        <= hash_pack_seq_in;
      r_hseq_vld         <= 1'b1;
      hash_pack_comp_out <= w_hseq_chg;
      // A packet ending on the same edge as a hash move keeps its bank marked written.
      if (w_hseq_chg) begin
        r_bank_written[r_hseq_prev] <= 1'b0;
      end
      if (w_pkt_end) begin
        r_bank_written[r_wr_bank] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_acc          <= 1'b0;
      r_rd_bank         <= {SEQ_WIDTH{1'b0}};
      r_rd_word         <= {ADDR_WIDTH{1'b0}};
      r_ram_acc         <= 1'b0;
      r_ram_bank        <= {SEQ_WIDTH{1'b0}};
      rd_data_valid_out <= 1'b0;
      rd_data_out       <= {DATA_WIDTH{1'b0}};
    end else begin
      r_rd_acc          <= w_hit_acc;
      r_rd_bank         <= hash_pack_seq_in;
      r_rd_word         <= w_hit_word;
      r_ram_acc         <= r_rd_acc;
      r_ram_bank        <= r_rd_bank;
      rd_data_valid_out <= r_ram_acc;
      if (r_ram_acc) begin
        rd_data_out <= w_ram_q[r_ram_bank];
      end
    end
  end

  for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
    pack_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .i_we    (w_we & (w_wbank == SEQ_WIDTH'(g))),
      .i_waddr (w_waddr),
      .i_wdata (data_in),
      .i_re    (r_rd_acc & (r_rd_bank == SEQ_WIDTH'(g))),
      .i_raddr (r_rd_word),
      .o_rdata (w_ram_q[g])
    );
  end

endmodule

// File: tb/tb_pack_ram_controller.sv
// Scoreboard bench for pack_ram_controller: a per-bank array model predicts
// every hit outcome and comp pulse; a monitor compares at the due cycle.
module tb_pack_ram_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] data_in = 64'd0;
  logic        data_valid_in = 1'b0;
  logic [9:0]  data_length_in = 10'd0;
  logic [2:0]  pack_seq_in = 3'd0;
  logic [2:0]  hash_pack_seq_in = 3'd0;
  logic        hash_hit_in = 1'b0;
  logic [9:0]  hash_addr_offset_in = 10'd0;
  logic        hash_pack_comp_out;
  logic        rd_data_valid_out;
  logic [63:0] rd_data_out;

  pack_ram_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .data_in             (data_in),
    .data_valid_in       (data_valid_in),
    .data_length_in      (data_length_in),
    .pack_seq_in         (pack_seq_in),
    .hash_pack_seq_in    (hash_pack_seq_in),
    .hash_hit_in         (hash_hit_in),
    .hash_addr_offset_in (hash_addr_offset_in),
    .hash_pack_comp_out  (hash_pack_comp_out),
    .rd_data_valid_out   (rd_data_valid_out),
    .rd_data_out         (rd_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          acc;
    logic [63:0] data;
  } exp_t;

  exp_t        rd_q[$];
  int          comp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] last_data = 64'd0;

  // Reference model: plain per-bank storage and bookkeeping
  logic [63:0] m_mem [8][1024];
  int          m_cnt [8];
  bit          m_written [8];
  bit          m_pv;
  int          m_cur;
  int          m_waddr;
  bit          m_hvld;
  int          m_hprev;
  logic [9:0]  pkt_len = 10'd0;
  logic [2:0]  hs = 3'd0;

  task automatic model_clear();
    for (int b = 0; b < 8; b++) begin
      m_cnt[b] = 0;
      m_written[b] = 1'b0;
    end
    m_pv = 1'b0; m_cur = 0; m_waddr = 0; m_hvld = 1'b0; m_hprev = 0;
  endtask

  // Applies the current inputs for the coming clock edge. xm: 0 model, 1 forced accept, 2 forced reject.
  task automatic model_cycle(input int xm, input logic [63:0] xd);
    int   w;
    int   hb;
    bit   acc;
    exp_t e;
    w  = int'(hash_addr_offset_in) / 8;
    hb = int'(hash_pack_seq_in);
    acc = hash_hit_in && (w < m_cnt[hb]) && (m_written[hb] || (m_pv && m_cur == hb));
    if (m_hvld && hb != m_hprev) begin
      comp_q.push_back(cyc + 1);
      m_written[m_hprev] = 1'b0;
    end
    m_hvld = 1'b1;
    m_hprev = hb;
    if (data_valid_in && !m_pv) begin
      m_cur = int'(pack_seq_in);
      m_mem[m_cur][0] = data_in;
      m_cnt[m_cur] = 1;
      m_waddr = 1;
    end else if (data_valid_in) begin
      if (m_waddr < 1024) begin
        m_mem[m_cur][m_waddr] = data_in;
        m_waddr++;
        m_cnt[m_cur] = m_waddr;
      end
    end else if (m_pv) begin
      m_written[m_cur] = 1'b1;
    end
    m_pv = data_valid_in;
    if (hash_hit_in) begin
      e.due = cyc + 3;
      if (xm == 1) begin
        e.acc = 1'b1; e.data = xd;
      end else if (xm == 2) begin
        e.acc = 1'b0; e.data = 64'd0;
      end else begin
        e.acc = acc; e.data = acc ? m_mem[hb][w] : 64'd0;
      end
      rd_q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [2:0] seq,
                       input logic hit, input logic [2:0] hseq, input logic [9:0] off,
                       input int xm, input logic [63:0] xd);
    @(negedge clk);
    data_valid_in = v; data_in = d; pack_seq_in = seq; data_length_in = pkt_len;
    hash_hit_in = hit; hash_pack_seq_in = hseq; hash_addr_offset_in = off;
    hs = hseq;
    model_cycle(xm, xd);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 64'd0, 3'd0, 1'b0, hs, 10'd0, 0, 64'd0);
  endtask

  task automatic check_zero(input string name, input logic [63:0] act);
    n_tests++;
    if (act !== 64'd0) begin
      n_fail++;
      $display("FAIL %s: got %h, required 0", name, act);
    end
  endtask

  // Asserts reset on a falling edge, checks outputs clear at once, releases two cycles later.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    last_data = 64'd0;
    rd_q.delete();
    comp_q.delete();
    model_clear();
    data_valid_in = 1'b0;
    hash_hit_in = 1'b0;
    #1;
    check_zero("reset_rd_valid", {63'd0, rd_data_valid_out});
    check_zero("reset_rd_data", rd_data_out);
    check_zero("reset_comp", {63'd0, hash_pack_comp_out});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_cycle(0, 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a read or comp result is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
          e = rd_q.pop_front();
          n_tests++;
          if (e.acc) begin
            if (rd_data_valid_out !== 1'b1 || rd_data_out !== e.data) begin
              n_fail++;
              $display("FAIL rd_hit cyc=%0d: got valid=%0b data=%h, required valid=1 data=%h",
                       cyc, rd_data_valid_out, rd_data_out, e.data);
            end
            last_data = e.data;
          end else if (rd_data_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_reject cyc=%0d: got valid=%0b, required 0", cyc, rd_data_valid_out);
          end
        end else if (rd_data_valid_out !== 1'b0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected cyc=%0d: got valid=%0b data=%h, required valid=0",
                   cyc, rd_data_valid_out, rd_data_out);
        end
        if (rd_data_valid_out === 1'b0) begin
          n_tests++;
          if (rd_data_out !== last_data) begin
            n_fail++;
            $display("FAIL rd_hold cyc=%0d: got %h, required %h", cyc, rd_data_out, last_data);
          end
        end
        if (comp_q.size() > 0 && comp_q[0] == cyc) begin
          void'(comp_q.pop_front());
          n_tests++;
          if (hash_pack_comp_out !== 1'b1) begin
            n_fail++;
            $display("FAIL comp_pulse cyc=%0d: got %0b, required 1", cyc, hash_pack_comp_out);
          end
        end else if (hash_pack_comp_out !== 1'b0) begin
          n_tests++;
          n_fail++;
          $display("FAIL comp_unexpected cyc=%0d: got %0b, required 0", cyc, hash_pack_comp_out);
        end
      end
    end
  end

  initial begin
    int         seq;
    int         len;
    int         b0, b1, b2;
    logic       hit;
    logic [9:0] off;
    logic [63:0] first_word;

    model_clear();
    do_reset();

    // seq 0, data 1..48, with directed hits during the packet
    pkt_len = 10'd48;
    for (int i = 0; i < 48; i++) begin
      case (i)
        34:      drive(1'b1, 64'(i + 1), 3'd0, 1'b1, 3'd0, 10'd24,  1, 64'h4);
        35:      drive(1'b1, 64'(i + 1), 3'd0, 1'b1, 3'd0, 10'd376, 2, 64'd0);
        36:      drive(1'b1, 64'(i + 1), 3'd0, 1'b1, 3'd0, 10'd48,  1, 64'h7);
        37:      drive(1'b1, 64'(i + 1), 3'd0, 1'b1, 3'd0, 10'd120, 1, 64'h10);
        default: drive(1'b1, 64'(i + 1), 3'd0, 1'b0, 3'd0, 10'd0,   0, 64'd0);
      endcase
    end
    idle(3);

    // seq 1, data 49..97
    pkt_len = 10'd49;
    for (int i = 0; i < 49; i++) drive(1'b1, 64'(49 + i), 3'd1, 1'b0, 3'd0, 10'd0, 0, 64'd0);
    idle(2);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd0, 10'd24, 1, 64'h4);
    idle(1);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd1, 10'd24, 1, 64'h34);
    idle(4);
    // bank 0 was released when the hash unit moved to seq 1
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd0, 10'd24, 2, 64'd0);
    idle(2);
    pkt_len = 10'd5;
    for (int i = 0; i < 5; i++) drive(1'b1, 64'(8'hA0 + i), 3'd0, 1'b0, 3'd0, 10'd0, 0, 64'd0);
    idle(2);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd0, 10'd8, 1, 64'hA1);
    idle(1);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd1, 10'd24, 2, 64'd0);
    idle(3);

    // 16 random packets of growing length, seq wrapping 7 -> 0, mid-packet reset in one
    for (int p = 0; p < 16; p++) begin
      seq = (p + 3) % 8;
      len = 20 + 4 * p;
      pkt_len = 10'(len);
      b0 = $urandom_range(len - 1, 0);
      b1 = $urandom_range(len - 1, 0);
      b2 = $urandom_range(len - 1, 0);
      for (int i = 0; i < len; i++) begin
        if (p == 10 && i == len / 2) do_reset();
        hit = (i == b0 || i == b1 || i == b2);
        off = 10'd0;
        if (hit) begin
          if ($urandom_range(1, 0) == 1) begin
            hs = 3'(seq);
            off = 10'($urandom_range(8 * i + 7, 0));
          end else begin
            hs = 3'($urandom_range(7, 0));
            off = 10'($urandom_range(1023, 0));
          end
        end
        drive(1'b1, {$urandom, $urandom}, 3'(seq), hit, hs, off, 0, 64'd0);
      end
      drive(1'b0, 64'd0, 3'd0, 1'b1, 3'(seq), 10'($urandom_range(8 * len - 1, 0)), 0, 64'd0);
      idle(1);
    end

    // oversized packet: beats past the last word must not wrap onto word 0
    pkt_len = 10'd1023;
    first_word = {$urandom, $urandom};
    drive(1'b1, first_word, 3'd5, 1'b0, hs, 10'd0, 0, 64'd0);
    for (int i = 1; i < 1030; i++) drive(1'b1, {$urandom, $urandom}, 3'd5, 1'b0, hs, 10'd0, 0, 64'd0);
    idle(2);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd5, 10'd0, 1, first_word);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd5, 10'd1016, 0, 64'd0);
    drive(1'b0, 64'd0, 3'd0, 1'b1, 3'd5, 10'd7, 0, 64'd0);
    idle(6);

    n_tests++;
    if (rd_q.size() != 0 || comp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d reads and %0d pulses outstanding, required 0 and 0",
               rd_q.size(), comp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
